// File: rtl/seq_alu.sv
// Registered multicycle ALU: single-cycle logic/add/sub plus iterative unsigned
// multiply (shift-add) and restoring divide, with a start/ready/done handshake.
module seq_alu #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rem,
  output logic             Z,
  output logic             C,
  output logic             N,
  output logic             V
);

  // Handshake: start is accepted only in a cycle where ready=1; done pulses for
  // exactly one cycle and result/rem/flags are valid from that cycle until the next done.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_MULU = 3'd5, OP_DIVU = 3'd6;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             op_q, op_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH:0]         prem_q, prem_d;
  logic [WIDTH-1:0]       result_q, result_d, rem_q, rem_d;
  logic                   z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;

  logic [WIDTH:0]         add_full, sub_full, mul_sum, div_shift, div_trial, div_prem_next;
  logic [2*WIDTH-1:0]     mul_next;
  logic [WIDTH-1:0]       div_quot_next, fin_res, fin_rem;
  logic                   div_ok, fin_c, fin_v, load;

  always_comb begin
    add_full      = {1'b0, a} + {1'b0, b};
    sub_full      = {1'b0, a} - {1'b0, b};
    // Multiplier sits in the low half of acc and is shifted out as the product shifts in.
    mul_sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : '0)};
    mul_next      = {mul_sum, acc_q[WIDTH-1:1]};
    // Dividend occupies acc low half; quotient bits shift in behind it.
    div_shift     = {prem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    div_trial     = div_shift - {1'b0, b_q};
    div_ok        = ~div_trial[WIDTH];
    div_prem_next = div_ok ? div_trial : div_shift;
    div_quot_next = {acc_q[WIDTH-2:0], div_ok};

    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    prem_d   = prem_q;
    result_d = result_q;
    rem_d    = rem_q;
    z_d      = z_q;
    c_d      = c_q;
    n_d      = n_q;
    v_d      = v_q;
    fin_res  = '0;
    fin_rem  = '0;
    fin_c    = 1'b0;
    fin_v    = 1'b0;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = alu_op;
          a_d   = a;
          b_d   = b;
          cnt_d = '0;
          case (alu_op)
            OP_ADD: begin
              fin_res = add_full[WIDTH-1:0];
              fin_c   = add_full[WIDTH];
              fin_v   = (a[WIDTH-1] == b[WIDTH-1]) && (fin_res[WIDTH-1] != a[WIDTH-1]);
              load    = 1'b1;
            end
            OP_SUB: begin
              fin_res = sub_full[WIDTH-1:0];
              fin_c   = sub_full[WIDTH];
              fin_v   = (a[WIDTH-1] != b[WIDTH-1]) && (fin_res[WIDTH-1] != a[WIDTH-1]);
              load    = 1'b1;
            end
            OP_AND: begin fin_res = a & b; load = 1'b1; end
            OP_OR:  begin fin_res = a | b; load = 1'b1; end
            OP_XOR: begin fin_res = a ^ b; load = 1'b1; end
            OP_MULU: begin
              acc_d   = {{WIDTH{1'b0}}, b};
              state_d = CALC;
            end
            OP_DIVU: begin
              if (b == '0) begin
                fin_res = '1;
                fin_rem = a;
                fin_v   = 1'b1;
                load    = 1'b1;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, a};
                prem_d  = '0;
                state_d = CALC;
              end
            end
            default: begin fin_res = b; load = 1'b1; end
          endcase
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MULU) begin
          acc_d   = mul_next;
          fin_res = mul_next[WIDTH-1:0];
          fin_c   = |mul_next[2*WIDTH-1:WIDTH];
        end else begin
          acc_d   = {acc_q[2*WIDTH-1:WIDTH], div_quot_next};
          prem_d  = div_prem_next;
          fin_res = div_quot_next;
          fin_rem = div_prem_next[WIDTH-1:0];
        end
        if (cnt_q == CNT_W'(WIDTH-1)) load = 1'b1;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d  = FIN;
      result_d = fin_res;
      rem_d    = fin_rem;
      z_d      = (fin_res == '0);
      n_d      = fin_res[WIDTH-1];
      c_d      = fin_c;
      v_d      = fin_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      prem_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      prem_q   <= prem_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      z_q      <= z_d;
      c_q      <= c_d;
      n_q      <= n_d;
      v_q      <= v_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = (state_q == FIN);
  assign result = result_q;
  assign rem    = rem_q;
  assign Z      = z_q;
  assign C      = c_q;
  assign N      = n_q;
  assign V      = v_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational 24-bit ALU of the multicycle computer.
- Adds iterative unsigned multiply and divide, a remainder output, an overflow flag and a start/done handshake.
- Sits between the register-file operand latches (A/B) and the ALUOut register.
- The control FSM issues `start` and waits on `done` instead of assuming single-cycle results.

Parameters:
- WIDTH, 24: operand/result width in bits; legal range 8..32.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only when ready=1.
- alu_op  input  3  operation code, sampled with start.
- a  input  WIDTH  operand A (dividend / multiplicand), sampled with start.
- b  input  WIDTH  operand B (divisor / multiplier), sampled with start.
- ready  output  1  high when a new start is accepted (state IDLE).
- done  output  1  one-cycle pulse; result/rem/flags valid from this cycle on.
- result  output  WIDTH  registered result, held until the next done.
- rem  output  WIDTH  remainder of DIVU; 0 for all other ops.
- Z  output  1  result == 0.
- C  output  1  carry/borrow/multiply-overflow.
- N  output  1  result[WIDTH-1].
- V  output  1  signed overflow (ADD/SUB) or divide-by-zero (DIVU).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=1, done=0.
  - result, rem, Z, C, N, V all 0.
  - Iteration counter and internal accumulators cleared.
  - Reset asserted mid-operation abandons it; no done pulse is produced.
- Opcodes:
  - 0 ADD: result = a+b; C = carry out of bit WIDTH-1; V = signed overflow.
  - 1 SUB: result = a-b; C = 1 when a<b unsigned (borrow); V = signed overflow.
  - 2 AND, 3 OR, 4 XOR, 7 PASSB (result=b): C=0, V=0.
  - 5 MULU: shift-add over WIDTH iterations. result = low WIDTH bits of the product; C = 1 if any high bit is nonzero; V=0.
  - 6 DIVU: restoring division over WIDTH iterations. result = quotient, rem = remainder; C=0, V=0.
  - DIVU with b==0: no iteration is performed; result = all ones, rem = a, V = 1, C = 0.
  - Z and N are always derived from the final result; rem is 0 for every op except DIVU.
- FSM states: IDLE, CALC, FIN.
  - IDLE: ready=1. start=1 latches alu_op, a, b.
    - Single-cycle ops and DIVU by zero go to FIN.
    - MULU/DIVU go to CALC with counter=0.
  - CALC: ready=0. One iteration per clock; counter increments. When counter==WIDTH-1, go to FIN.
  - FIN: result, rem and flags are written. done=1 for this one cycle; ready=0. Next state is IDLE.
- Latency, start in cycle t:
  - Single-cycle ops: done in cycle t+1.
  - MULU/DIVU: done in cycle t+WIDTH+1 (25 for WIDTH=24).
- start while ready=0 is ignored; no queuing, no error.
- Operand changes after acceptance have no effect on the operation in progress.
- Outputs hold their last values between done pulses; they do not change during CALC.
- Back-to-back operation: a start in the cycle after FIN (IDLE again) is accepted. Throughput is 1 op per 2 cycles for single-cycle ops.
- All arithmetic is modulo 2^WIDTH. The multiply accumulator is 2*WIDTH bits. The divide partial remainder is WIDTH+1 bits.

Test Plan (WIDTH=24):
- ADD a=500, b=500 → result=1000, Z=0, C=0, N=0, V=0; done exactly 1 cycle after start.
- SUB a=100, b=100 → result=0, Z=1, C=0, N=0. Then SUB a=100, b=400 → result=24'hFFFED4, N=1, C=1, V=0.
- MULU a=1000, b=1000 → result=24'h0F4240, C=0; done 25 cycles after start, with ready=0 throughout.
  - MULU a=24'h001000, b=24'h001000 → result=0, Z=1, C=1.
- DIVU a=1000, b=7 → result=142, rem=6, V=0.
  - DIVU a=55, b=0 → result=24'hFFFFFF, rem=55, V=1; done 1 cycle after start.
- Pulse start with ADD during a MULU's CALC phase → the ADD is ignored and only the MULU done/result appears.
  - Pull rst_n low mid-DIVU → all outputs go to 0 asynchronously, ready=1, and no done pulse follows.
